// File: rtl/inst_fetch.sv
// inst_fetch: owns the PC, fetches from the combinational instruction ROM and
// buffers {pc, inst} pairs in a 2-entry prefetch FIFO toward decode.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_en_out,
  output logic [31:0] rom_addr_out,
  input  logic [31:0] rom_inst_in,
  input  logic        branch_flag_in,
  input  logic [31:0] branch_target_in,
  input  logic        id_ready_in,
  output logic        if_valid_out,
  output logic [31:0] if_pc_out,
  output logic [31:0] if_inst_out
);
  logic [31:0] pc;
  logic [31:0] fifo_pc [2];
  logic [31:0] fifo_inst [2];
  logic [1:0]  count;
  logic        wptr, rptr, pop, fetch;
  // a redirect hides the head so a stale entry can never be consumed
  always_comb begin
    if_valid_out = !rst && !branch_flag_in && count != 2'd0;
    pop          = if_valid_out && id_ready_in;
    fetch        = !rst && !branch_flag_in && (count != 2'd2 || pop);
    rom_en_out   = fetch;
    rom_addr_out = fetch ? pc : '0;
    if_pc_out    = if_valid_out ? fifo_pc[rptr] : '0;
    if_inst_out  = if_valid_out ? fifo_inst[rptr] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      count <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else if (branch_flag_in) begin
      pc    <= {branch_target_in[31:2], 2'b00};
      count <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
    end else begin
      if (fetch) begin
        wptr <= !wptr;
        pc   <= pc + 32'd4;
      end
      if (pop) rptr <= !rptr;
      count <= count + {1'b0, fetch && !pop} - {1'b0, pop && !fetch};
    end
  end
  always_ff @(posedge clk) begin
    if (fetch) begin
      fifo_pc[wptr]   <= pc;
      fifo_inst[wptr] <= rom_inst_in;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed vector table, wrap-around sequence and a queue-based
// scoreboard run with random ready/branch traffic.
module tb_inst_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1, br = 1'b0, rdy = 1'b1;
  logic [31:0] tgt = '0;
  logic        en, valid;
  logic [31:0] addr, inst, pc, ins;
  logic        rst_w = 1'b1;
  logic        w_en, w_valid;
  logic [31:0] w_addr, w_inst, w_pc, w_ins;
  int total = 0, bad = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign inst   = en ? mem(addr) : '0;
  assign w_inst = w_en ? mem(w_addr) : '0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .rom_en_out(en), .rom_addr_out(addr), .rom_inst_in(inst),
    .branch_flag_in(br), .branch_target_in(tgt), .id_ready_in(rdy),
    .if_valid_out(valid), .if_pc_out(pc), .if_inst_out(ins)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst_w), .rom_en_out(w_en), .rom_addr_out(w_addr), .rom_inst_in(w_inst),
    .branch_flag_in(1'b0), .branch_target_in(32'h0), .id_ready_in(1'b1),
    .if_valid_out(w_valid), .if_pc_out(w_pc), .if_inst_out(w_ins)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic r; logic b; logic [31:0] t; logic rd;
    logic e; logic [31:0] a; logic v; logic [31:0] p;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic b, input logic [31:0] t, input logic rd,
                              input logic e, input logic [31:0] a, input logic v, input logic [31:0] p);
    return '{r: r, b: b, t: t, rd: rd, e: e, a: a, v: v, p: p};
  endfunction

  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  ent_t q[$];

  vec_t vecs [27];
  logic [31:0] wa [5];
  logic        wv [5];
  logic [31:0] wp [5];
  logic [31:0] mpc;
  logic        ev, p, f;

  initial begin
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h8);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1, 32'hC);
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h14,  1'b1, 32'h10);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h10);
    vecs[10] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h10);
    vecs[11] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h18,  1'b1, 32'h10);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h1C,  1'b1, 32'h14);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h20,  1'b1, 32'h18);
    vecs[14] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, 32'h1C);
    vecs[15] = mk(1'b0, 1'b1, 32'h103, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
    vecs[16] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    vecs[17] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h100);
    vecs[18] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b1, 32'h104);
    vecs[19] = mk(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    vecs[20] = mk(1'b0, 1'b1, 32'h304, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    vecs[21] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h304, 1'b0, 32'h0);
    vecs[22] = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h308, 1'b1, 32'h304);
    vecs[23] = mk(1'b1, 1'b1, 32'h500, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0);
    vecs[24] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0);
    vecs[25] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b1, 32'h0);
    vecs[26] = mk(1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h4);
    wa = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    wv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    wp = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      rst = vecs[i].r; br = vecs[i].b; tgt = vecs[i].t; rdy = vecs[i].rd;
      #1;
      check($sformatf("vec%0d en", i), {31'b0, en}, {31'b0, vecs[i].e});
      check($sformatf("vec%0d addr", i), addr, vecs[i].a);
      check($sformatf("vec%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].v});
      check($sformatf("vec%0d pc", i), pc, vecs[i].p);
      check($sformatf("vec%0d inst", i), ins, vecs[i].v ? mem(vecs[i].p) : 32'h0);
    end

    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rst_w = 1'b0;
      #1;
      check($sformatf("wrap%0d addr", k), w_addr, wa[k]);
      check($sformatf("wrap%0d valid", k), {31'b0, w_valid}, {31'b0, wv[k]});
      check($sformatf("wrap%0d pc", k), w_pc, wp[k]);
      check($sformatf("wrap%0d inst", k), w_ins, wv[k] ? mem(wp[k]) : 32'h0);
    end

    @(negedge clk);
    rst = 1'b1; br = 1'b0; rdy = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mpc = 32'h0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      #1;
      ev = !br && q.size() != 0;
      check("sb valid", {31'b0, valid}, {31'b0, ev});
      if (ev) begin
        check("sb pc", pc, q[0].pc);
        check("sb inst", ins, q[0].inst);
      end
      p = ev && rdy;
      f = !br && (q.size() < 2 || p);
      check("sb en", {31'b0, en}, {31'b0, f});
      check("sb addr", addr, f ? mpc : 32'h0);
      if (br) begin
        q.delete();
        mpc = {tgt[31:2], 2'b00};
      end else begin
        if (p) void'(q.pop_front());
        if (f) begin
          q.push_back({mpc, mem(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
